// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
// Module   : ifetch
// Purpose  : Instruction fetch unit with 2-credit request issue and a 2-entry
//            registered instruction buffer, with redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic [31:0] r_fpc;
    logic [1:0]  r_outst;
    logic [1:0]  r_kill;
    logic [1:0]  r_fifo_count;
    logic        r_fifo_wr;
    logic        r_fifo_rd;
    logic [31:0] r_fifo_inst [2];
    logic [31:0] r_fifo_pc   [2];
    logic        r_ifq_wr;
    logic        r_ifq_rd;
    logic [31:0] r_ifq_pc    [2];

    logic        w_credit;
    logic        w_grant;
    logic        w_accept;
    logic        w_pop;
    logic        w_unused_lsbs;

    // Redirect targets are forced word aligned, so the low bits are dropped.
    assign w_unused_lsbs = ^redirect_pc[1:0];

    assign w_credit  = ({1'b0, r_fifo_count} + {1'b0, r_outst}) < 3'd2;
    assign imem_req  = rst_n & ~redirect & w_credit;
    assign imem_addr = r_fpc;
    assign w_grant   = imem_req & imem_gnt;
    assign w_accept  = imem_rvalid & (r_kill == 2'd0) & ~redirect;
    assign w_pop     = inst_valid & inst_ready & ~redirect;

    assign inst_valid = (r_fifo_count != 2'd0);
    assign inst       = inst_valid ? r_fifo_inst[r_fifo_rd] : c_NOP;
    assign inst_pc    = inst_valid ? r_fifo_pc[r_fifo_rd]   : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fpc          <= RESET_PC;
            r_outst        <= 2'd0;
            r_kill         <= 2'd0;
            r_fifo_count   <= 2'd0;
            r_fifo_wr      <= 1'b0;
            r_fifo_rd      <= 1'b0;
            r_fifo_inst[0] <= 32'h0;
            r_fifo_inst[1] <= 32'h0;
            r_fifo_pc[0]   <= 32'h0;
            r_fifo_pc[1]   <= 32'h0;
            r_ifq_wr       <= 1'b0;
            r_ifq_rd       <= 1'b0;
            r_ifq_pc[0]    <= 32'h0;
            r_ifq_pc[1]    <= 32'h0;
        end else begin
            // The in-flight queue retires one entry per response, dropped or not,
            // so its occupancy always equals r_outst.
            r_outst <= r_outst + {1'b0, w_grant} - {1'b0, imem_rvalid};
            if (w_grant) begin
                r_ifq_pc[r_ifq_wr] <= r_fpc;
                r_ifq_wr           <= ~r_ifq_wr;
            end
            if (imem_rvalid) begin
                r_ifq_rd <= ~r_ifq_rd;
            end

            if (redirect) begin
                r_fpc        <= {redirect_pc[31:2], 2'b00};
                r_fifo_count <= 2'd0;
                r_fifo_wr    <= 1'b0;
                r_fifo_rd    <= 1'b0;
                // Every response still owed after this cycle belongs to the old path.
                r_kill       <= r_outst - {1'b0, imem_rvalid};
            end else begin
                if (w_grant) begin
                    r_fpc <= r_fpc + 32'd4;
                end
                if (imem_rvalid && (r_kill != 2'd0)) begin
                    r_kill <= r_kill - 2'd1;
                end
                if (w_accept) begin
                    r_fifo_inst[r_fifo_wr] <= imem_rdata;
                    r_fifo_pc[r_fifo_wr]   <= r_ifq_pc[r_ifq_rd];
                    r_fifo_wr              <= ~r_fifo_wr;
                end
                if (w_pop) begin
                    r_fifo_rd <= ~r_fifo_rd;
                end
                r_fifo_count <= r_fifo_count + {1'b0, w_accept} - {1'b0, w_pop};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch
// Purpose  : Directed self-checking bench for ifetch with an in-order memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;
    localparam logic [31:0] c_XOR      = 32'h1357_9BDF;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_grant = 0;
    bit          mem_en  = 1'b1;
    logic [31:0] pend[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];

    ifetch #(.RESET_PC(c_RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory bookkeeping and decode-side monitor, using pre-edge values.
    always @(posedge clk) begin
        if (!rst_n) begin
            pend.delete();
        end else begin
            if (imem_rvalid) void'(pend.pop_front());
            if (imem_req && imem_gnt) begin
                pend.push_back(imem_addr);
                n_grant++;
            end
            if (inst_valid && inst_ready && !redirect) begin
                got_pc.push_back(inst_pc);
                got_inst.push_back(inst);
            end
        end
    end

    // Responses come back in order, no earlier than one cycle after grant.
    always @(negedge clk) begin
        if (mem_en && rst_n && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0] ^ c_XOR;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    function automatic logic [31:0] got_at(input int i);
        return (i < got_pc.size()) ? got_pc[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] got_inst_at(input int i);
        return (i < got_inst.size()) ? got_inst[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_req"},   imem_req,   1'b0);
        chk1({tag, "_valid"}, inst_valid, 1'b0);
        chk ({tag, "_inst"},  inst,       c_NOP);
        chk ({tag, "_pc"},    inst_pc,    32'h0);
        chk ({tag, "_addr"},  imem_addr,  c_RESET_PC);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_before;
        bit  found;

        rst_n       = 1'b0;
        imem_gnt    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;
        repeat (2) tick();
        check_reset_outputs("reset");

        // Streaming with a zero-wait memory.
        inst_ready = 1'b1;
        got_pc.delete();
        got_inst.delete();
        rst_n = 1'b1;
        #1;
        chk1("rel_req", imem_req, 1'b1);
        chk ("rel_addr", imem_addr, c_RESET_PC);
        repeat (14) tick();
        chk1("stream_count", got_pc.size() >= 5, 1'b1);
        for (int i = 0; i < got_pc.size(); i++) begin
            chk("stream_pc",   got_pc[i],   32'(4 * i));
            chk("stream_inst", got_inst[i], 32'(4 * i) ^ c_XOR);
        end

        // Reset mid-stream takes effect immediately.
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");

        // Decode stall: only two fetches may be issued.
        inst_ready = 1'b0;
        tick();
        tick();
        n_grant = 0;
        rst_n = 1'b1;
        #1;
        chk1("stall_rel_req", imem_req, 1'b1);
        chk ("stall_rel_addr", imem_addr, c_RESET_PC);
        repeat (5) tick();
        chk("stall_pc_mid", inst_pc, 32'h0);
        repeat (5) tick();
        chk ("stall_grants", n_grant, 32'd2);
        chk1("stall_req",    imem_req, 1'b0);
        chk1("stall_valid",  inst_valid, 1'b1);
        chk ("stall_pc",     inst_pc, 32'h0);
        chk ("stall_inst",   inst, 32'h0 ^ c_XOR);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk ("stall_head2_pc",   inst_pc, 32'h4);
        chk ("stall_head2_inst", inst, 32'h4 ^ c_XOR);
        chk1("stall_req_after_pop", imem_req, 1'b1);
        chk ("stall_addr_after_pop", imem_addr, 32'h8);

        // Redirect with two requests outstanding and memory holding responses.
        rst_n      = 1'b0;
        mem_en     = 1'b0;
        inst_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk1("out2_req",   imem_req, 1'b0);
        chk1("out2_valid", inst_valid, 1'b0);
        chk ("out2_addr",  imem_addr, 32'h8);
        got_pc.delete();
        got_inst.delete();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        #1;
        chk1("redir1_req", imem_req, 1'b0);
        tick();
        redirect = 1'b0;
        mem_en   = 1'b1;
        #1;
        chk ("redir1_addr", imem_addr, 32'h100);
        chk1("redir1_req_after", imem_req, 1'b0);
        repeat (12) tick();
        chk("redir1_first_pc",   got_at(0), 32'h100);
        chk("redir1_first_inst", got_inst_at(0), 32'h100 ^ c_XOR);
        chk("redir1_second_pc",  got_at(1), 32'h104);

        // Redirect in the same cycle as a response and a pop.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (imem_rvalid && inst_valid) found = 1'b1;
        end
        chk1("redir2_found", found, 1'b1);
        n_before    = got_pc.size();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        chk1("redir2_req", imem_req, 1'b0);
        tick();
        redirect = 1'b0;
        #1;
        chk1("redir2_valid", inst_valid, 1'b0);
        chk ("redir2_inst",  inst, c_NOP);
        chk ("redir2_pc",    inst_pc, 32'h0);
        chk ("redir2_addr",  imem_addr, 32'h200);
        chk1("redir2_no_pop", got_pc.size() == n_before, 1'b1);
        repeat (10) tick();
        chk("redir2_first_pc", got_at(n_before), 32'h200);

        // Misaligned redirect at the top of the address space wraps to zero.
        n_before    = got_pc.size();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        #1;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (imem_req) found = 1'b1;
            else tick();
        end
        chk1("wrap_req_seen", found, 1'b1);
        tick();
        chk("wrap_next_addr", imem_addr, 32'h0);
        repeat (10) tick();
        chk("wrap_first_pc",   got_at(n_before), 32'hFFFF_FFFC);
        chk("wrap_first_inst", got_inst_at(n_before), 32'hFFFF_FFFC ^ c_XOR);
        chk("wrap_second_pc",  got_at(n_before + 1), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
